// File: rtl/reg_issue_ctrl_pkg.sv
// Shared constants for the register/issue controller: ROB id width and buffer state encoding.
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

package reg_issue_ctrl_pkg;

  localparam int ROB_W = `ROB_WIDTH_BIT;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use_rs1;
    logic        use_rs2;
    logic        is_mem;
    logic [31:0] info;
  } dec_entry_t;

  // Register id presented to the register file; 0 means "no source".
  function automatic logic [4:0] src_id(input logic used, input logic [4:0] id);
    return used ? id : 5'd0;
  endfunction

endpackage

// File: rtl/reg_issue_ctrl_buf.sv
// issue_buf: one-entry valid/ready holding register between decode and issue.
module issue_buf
  import reg_issue_ctrl_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  input  logic       clear_in,
  input  logic       in_valid_i,
  input  dec_entry_t in_data_i,
  output logic       in_ready_o,
  input  logic       issue_i,
  output logic       full_o,
  output dec_entry_t data_o
);

  buf_state_e state_q, state_d;
  dec_entry_t data_q;
  logic       load;

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // A flush empties the entry even while paused.
  always_comb begin
    state_d = state_q;
    if (clear_in) begin
      state_d = ST_EMPTY;
    end else if (rdy_in) begin
      case (state_q)
        ST_EMPTY: if (in_valid_i) state_d = ST_FULL;
        ST_FULL:  if (issue_i && !in_valid_i) state_d = ST_EMPTY;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    full_o     = (state_q == ST_FULL);
    in_ready_o = !clear_in && (!full_o || issue_i);
  end

  assign load   = rdy_in && in_valid_i && in_ready_o;
  assign data_o = data_q;

  always_ff @(posedge clk_in) begin
    if (rst_in)    data_q <= '0;
    else if (load) data_q <= in_data_i;
  end

endmodule

// File: rtl/reg_issue_ctrl.sv
// Rename/issue stage: buffers one decoded op, queries the register file and issues to RS or LSB.
// Optional counters stat_issued/stat_stall are compiled in with ISSUE_STAT_EN.
module reg_issue_ctrl
  import reg_issue_ctrl_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_flag,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [4:0]       dec_rd,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_use_rs1,
  input  logic             dec_use_rs2,
  input  logic             dec_is_mem,
  input  logic [31:0]      dec_info,
  input  logic             rob_full,
  input  logic [ROB_W-1:0] rob_tail,
  input  logic             rs_full,
  input  logic             lsb_full,
  output logic [4:0]       ask_reg_id1,
  output logic [4:0]       ask_reg_id2,
  output logic [4:0]       new_reg_id,
  output logic [ROB_W-1:0] new_ROB_id,
  input  logic [31:0]      rf_val1,
  input  logic [31:0]      rf_val2,
  input  logic             rf_dep1,
  input  logic             rf_dep2,
  input  logic [ROB_W-1:0] rf_rob1,
  input  logic [ROB_W-1:0] rf_rob2,
  output logic             iss_rs_valid,
  output logic             iss_lsb_valid,
  output logic [31:0]      iss_info,
  output logic [31:0]      iss_v1,
  output logic [31:0]      iss_v2,
  output logic [ROB_W-1:0] iss_q1,
  output logic [ROB_W-1:0] iss_q2,
  output logic             iss_dep1,
  output logic             iss_dep2,
  output logic [ROB_W-1:0] iss_rob_id,
`ifdef ISSUE_STAT_EN
  output logic [31:0]      stat_issued,
  output logic [31:0]      stat_stall,
`endif
  output logic             rob_alloc
);

  dec_entry_t dec_in, cur;
  logic       buf_full, issue, live1, live2;

  logic             rs_valid_q, lsb_valid_q, rob_alloc_q, dep1_q, dep2_q;
  logic [4:0]       new_reg_q;
  logic [ROB_W-1:0] new_rob_q, rob_id_q, q1_q, q2_q;
  logic [31:0]      info_q, v1_q, v2_q;

  assign dec_in = '{rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2, use_rs1: dec_use_rs1,
                    use_rs2: dec_use_rs2, is_mem: dec_is_mem, info: dec_info};

  issue_buf u_buf (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .clear_in   (clear_flag),
    .in_valid_i (dec_valid),
    .in_data_i  (dec_in),
    .in_ready_o (dec_ready),
    .issue_i    (issue),
    .full_o     (buf_full),
    .data_o     (cur)
  );

  assign issue = buf_full && rdy_in && !clear_flag && !rob_full &&
                 !(cur.is_mem ? lsb_full : rs_full);

  assign ask_reg_id1 = buf_full ? src_id(cur.use_rs1, cur.rs1) : 5'd0;
  assign ask_reg_id2 = buf_full ? src_id(cur.use_rs2, cur.rs2) : 5'd0;
  assign live1       = cur.use_rs1 && (cur.rs1 != 5'd0);
  assign live2       = cur.use_rs2 && (cur.rs2 != 5'd0);

  always_ff @(posedge clk_in) begin
    if (rst_in || clear_flag) begin
      rs_valid_q  <= 1'b0;
      lsb_valid_q <= 1'b0;
      rob_alloc_q <= 1'b0;
      new_reg_q   <= '0;
      new_rob_q   <= '0;
      rob_id_q    <= '0;
      info_q      <= '0;
      v1_q        <= '0;
      v2_q        <= '0;
      q1_q        <= '0;
      q2_q        <= '0;
      dep1_q      <= 1'b0;
      dep2_q      <= 1'b0;
    end else if (rdy_in) begin
      rs_valid_q  <= issue && !cur.is_mem;
      lsb_valid_q <= issue && cur.is_mem;
      rob_alloc_q <= issue;
      new_reg_q   <= issue ? cur.rd : 5'd0;
      new_rob_q   <= issue ? rob_tail : '0;
      if (issue) begin
        rob_id_q <= rob_tail;
        info_q   <= cur.info;
        v1_q     <= live1 ? rf_val1 : 32'd0;
        v2_q     <= live2 ? rf_val2 : 32'd0;
        q1_q     <= live1 ? rf_rob1 : '0;
        q2_q     <= live2 ? rf_rob2 : '0;
        dep1_q   <= live1 && rf_dep1;
        dep2_q   <= live2 && rf_dep2;
      end
    end
  end

  assign iss_rs_valid  = rs_valid_q;
  assign iss_lsb_valid = lsb_valid_q;
  assign rob_alloc     = rob_alloc_q;
  assign new_reg_id    = new_reg_q;
  assign new_ROB_id    = new_rob_q;
  assign iss_rob_id    = rob_id_q;
  assign iss_info      = info_q;
  assign iss_v1        = v1_q;
  assign iss_v2        = v2_q;
  assign iss_q1        = q1_q;
  assign iss_q2        = q2_q;
  assign iss_dep1      = dep1_q;
  assign iss_dep2      = dep2_q;

`ifdef ISSUE_STAT_EN
  logic [31:0] stat_issued_q, stat_stall_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else if (rdy_in) begin
      stat_issued_q <= stat_issued_q + {31'd0, issue};
      stat_stall_q  <= stat_stall_q + {31'd0, buf_full && !issue};
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_reg_issue_ctrl.sv
// Bench for reg_issue_ctrl: directed vector table plus randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_reg_issue_ctrl;
  import reg_issue_ctrl_pkg::*;
  localparam int RW = ROB_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_in, rdy_in, clear_flag, dec_valid, dec_ready;
  logic [4:0] dec_rd, dec_rs1, dec_rs2;
  logic dec_use_rs1, dec_use_rs2, dec_is_mem;
  logic [31:0] dec_info;
  logic rob_full, rs_full, lsb_full;
  logic [RW-1:0] rob_tail;
  logic [4:0] ask_reg_id1, ask_reg_id2, new_reg_id;
  logic [RW-1:0] new_ROB_id;
  logic [31:0] rf_val1, rf_val2;
  logic rf_dep1, rf_dep2;
  logic [RW-1:0] rf_rob1, rf_rob2;
  logic iss_rs_valid, iss_lsb_valid, iss_dep1, iss_dep2, rob_alloc;
  logic [31:0] iss_info, iss_v1, iss_v2;
  logic [RW-1:0] iss_q1, iss_q2, iss_rob_id;
`ifdef ISSUE_STAT_EN
  logic [31:0] stat_issued, stat_stall;
`endif

  reg_issue_ctrl dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clear_flag(clear_flag),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_rd(dec_rd), .dec_rs1(dec_rs1),
    .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_is_mem(dec_is_mem), .dec_info(dec_info), .rob_full(rob_full), .rob_tail(rob_tail),
    .rs_full(rs_full), .lsb_full(lsb_full), .ask_reg_id1(ask_reg_id1), .ask_reg_id2(ask_reg_id2),
    .new_reg_id(new_reg_id), .new_ROB_id(new_ROB_id), .rf_val1(rf_val1), .rf_val2(rf_val2),
    .rf_dep1(rf_dep1), .rf_dep2(rf_dep2), .rf_rob1(rf_rob1), .rf_rob2(rf_rob2),
    .iss_rs_valid(iss_rs_valid), .iss_lsb_valid(iss_lsb_valid), .iss_info(iss_info),
    .iss_v1(iss_v1), .iss_v2(iss_v2), .iss_q1(iss_q1), .iss_q2(iss_q2),
    .iss_dep1(iss_dep1), .iss_dep2(iss_dep2), .iss_rob_id(iss_rob_id),
`ifdef ISSUE_STAT_EN
    .stat_issued(stat_issued), .stat_stall(stat_stall),
`endif
    .rob_alloc(rob_alloc)
  );

  typedef struct packed {
    logic rst, rdy, clear, dv;
    logic [4:0] rd, rs1, rs2;
    logic u1, u2, mem;
    logic [31:0] info;
    logic rob_full;
    logic [RW-1:0] tail;
    logic rs_full, lsb_full;
  } in_t;

  typedef struct packed {
    logic rs_v, lsb_v, alloc;
    logic [4:0] new_reg;
    logic [RW-1:0] new_rob, rob_id;
    logic [31:0] info, v1, v2;
    logic [RW-1:0] q1, q2;
    logic dep1, dep2;
  } out_t;

  typedef struct {
    in_t i;
    logic ready, rs_v, lsb_v;
    logic [4:0] new_reg;
    logic [RW-1:0] new_rob, rob_id;
    logic chk_dep, dep1;
    logic [RW-1:0] q1;
  } vec_t;

  int n_chk = 0, n_err = 0;

  // Register-file stand-in: scoreboard of renamed registers plus same-cycle forwarding.
  logic busy[32];
  logic [RW-1:0] robtab[32];
  logic [31:0] regval[32];

  // Reference model state.
  logic m_full;
  in_t m_ins;
  out_t m_out;
  int unsigned m_iss, m_stall;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [RW+32:0] rf_ans(input logic [4:0] id, input logic [4:0] fid,
                                            input logic [RW-1:0] frob);
    if (id != 5'd0 && id == fid) return {1'b1, frob, regval[id]};
    return {busy[id], robtab[id], regval[id]};
  endfunction

  function automatic out_t dut_out();
    return '{rs_v: iss_rs_valid, lsb_v: iss_lsb_valid, alloc: rob_alloc, new_reg: new_reg_id,
             new_rob: new_ROB_id, rob_id: iss_rob_id, info: iss_info, v1: iss_v1, v2: iss_v2,
             q1: iss_q1, q2: iss_q2, dep1: iss_dep1, dep2: iss_dep2};
  endfunction

  function automatic in_t vin(input logic rst, clear, dv, input logic [4:0] rd, rs1, rs2,
                              input logic u1, u2, mem, rsf, lsbf, input logic [RW-1:0] tail);
    in_t t;
    t = '{rst: rst, rdy: 1'b1, clear: clear, dv: dv, rd: rd, rs1: rs1, rs2: rs2, u1: u1, u2: u2,
          mem: mem, info: {8'hC0, 3'b0, rd, 3'b0, rs1, 3'b0, rs2}, rob_full: 1'b0, tail: tail,
          rs_full: rsf, lsb_full: lsbf};
    return t;
  endfunction

  function automatic vec_t vr(input in_t i, input logic ready, rs_v, lsb_v, input logic [4:0] nr,
                              input logic [RW-1:0] nrob, rid, input logic cd, d1,
                              input logic [RW-1:0] q1);
    vec_t v;
    v = '{i: i, ready: ready, rs_v: rs_v, lsb_v: lsb_v, new_reg: nr, new_rob: nrob,
          rob_id: rid, chk_dep: cd, dep1: d1, q1: q1};
    return v;
  endfunction

  task automatic drive(input in_t t);
    rst_in = t.rst; rdy_in = t.rdy; clear_flag = t.clear; dec_valid = t.dv;
    dec_rd = t.rd; dec_rs1 = t.rs1; dec_rs2 = t.rs2; dec_use_rs1 = t.u1; dec_use_rs2 = t.u2;
    dec_is_mem = t.mem; dec_info = t.info; rob_full = t.rob_full; rob_tail = t.tail;
    rs_full = t.rs_full; lsb_full = t.lsb_full;
  endtask

  // One clock cycle: apply inputs, check combinational outputs, advance the model, check registers.
  task automatic step(input in_t t, output logic ready_seen);
    logic can, iss, rdy_exp, l1, l2;
    logic [4:0] a1, a2, old_reg;
    logic [RW-1:0] old_rob;
    logic [RW+32:0] r1, r2;
    out_t o;
    drive(t);
    #1;
    {rf_dep1, rf_rob1, rf_val1} = rf_ans(ask_reg_id1, new_reg_id, new_ROB_id);
    {rf_dep2, rf_rob2, rf_val2} = rf_ans(ask_reg_id2, new_reg_id, new_ROB_id);
    #1;
    can = m_full && !t.rob_full && !(m_ins.mem ? t.lsb_full : t.rs_full);
    iss = can && t.rdy && !t.clear;
    rdy_exp = !t.clear && (!m_full || iss);
    a1 = (m_full && m_ins.u1) ? m_ins.rs1 : 5'd0;
    a2 = (m_full && m_ins.u2) ? m_ins.rs2 : 5'd0;
    ready_seen = dec_ready;
    chk("dec_ready", {127'd0, dec_ready}, {127'd0, rdy_exp});
    chk("ask_ids", {118'd0, ask_reg_id1, ask_reg_id2}, {118'd0, a1, a2});
    r1 = rf_ans(a1, m_out.new_reg, m_out.new_rob);
    r2 = rf_ans(a2, m_out.new_reg, m_out.new_rob);
    old_reg = m_out.new_reg;
    old_rob = m_out.new_rob;
    if (t.rst) begin
      m_full = 1'b0; m_out = '0; m_iss = 0; m_stall = 0;
    end else begin
      if (t.rdy) begin
        m_iss += iss ? 1 : 0;
        m_stall += (m_full && !iss) ? 1 : 0;
      end
      if (t.clear) begin
        m_full = 1'b0; m_out = '0;
      end else if (t.rdy) begin
        o = m_out;
        o.rs_v = iss && !m_ins.mem;
        o.lsb_v = iss && m_ins.mem;
        o.alloc = iss;
        o.new_reg = iss ? m_ins.rd : 5'd0;
        o.new_rob = iss ? t.tail : '0;
        if (iss) begin
          l1 = m_ins.u1 && m_ins.rs1 != 5'd0;
          l2 = m_ins.u2 && m_ins.rs2 != 5'd0;
          o.rob_id = t.tail;
          o.info = m_ins.info;
          o.v1 = l1 ? r1[31:0] : 32'd0;
          o.v2 = l2 ? r2[31:0] : 32'd0;
          o.q1 = l1 ? r1[RW+31:32] : '0;
          o.q2 = l2 ? r2[RW+31:32] : '0;
          o.dep1 = l1 && r1[RW+32];
          o.dep2 = l2 && r2[RW+32];
        end
        m_out = o;
        if (t.dv && rdy_exp) begin
          m_full = 1'b1; m_ins = t;
        end else if (iss) begin
          m_full = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("issue_regs", {6'd0, dut_out()}, {6'd0, m_out});
`ifdef ISSUE_STAT_EN
    chk("stats", {64'd0, stat_issued, stat_stall}, {64'd0, m_iss, m_stall});
`endif
    if (old_reg != 5'd0) begin
      busy[old_reg] = 1'b1;
      robtab[old_reg] = old_rob;
    end
    if ($urandom_range(7) == 0) busy[$urandom_range(31, 1)] = 1'b0;
  endtask

  vec_t vec[20];

  initial begin
    logic rs;
    in_t t;
    int unsigned st0;
    st0 = 0;
    for (int r = 0; r < 32; r++) begin
      busy[r] = 1'b0;
      robtab[r] = r[RW-1:0];
      regval[r] = $urandom;
    end
    busy[0] = 1'b1;
    regval[0] = 32'hDEAD0000;
    rf_val1 = '0; rf_val2 = '0; rf_dep1 = 0; rf_dep2 = 0; rf_rob1 = '0; rf_rob2 = '0;
    m_full = 1'b0; m_out = '0; m_iss = 0; m_stall = 0; m_ins = '0;

    t = vin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(t);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_regs", {6'd0, dut_out()}, 128'd0);
    chk("reset_ready", {127'd0, dec_ready}, 128'd1);
    chk("reset_ask", {118'd0, ask_reg_id1, ask_reg_id2}, 128'd0);
`ifdef ISSUE_STAT_EN
    chk("reset_stats", {64'd0, stat_issued, stat_stall}, 128'd0);
`endif

    //             rst clr dv rd rs1 rs2 u1 u2 mem rsf lsbf tail  rdy rs lsb nreg nrob rid cd d1 q1
    vec[0]  = vr(vin(0, 0, 1, 5, 1, 2, 1, 1, 0, 0, 0, 3),  1, 0, 0, 0, 0, 0, 0, 0, 0);
    vec[1]  = vr(vin(0, 0, 1, 6, 5, 7, 1, 1, 0, 0, 0, 3),  1, 1, 0, 5, 3, 3, 0, 0, 0);
    vec[2]  = vr(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4),  1, 1, 0, 6, 4, 4, 1, 1, 3);
    vec[3]  = vr(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),  1, 0, 0, 0, 0, 0, 0, 0, 0);
    vec[4]  = vr(vin(0, 0, 1, 7, 0, 0, 0, 0, 0, 1, 0, 0),  1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 5; k <= 8; k++)
      vec[k] = vr(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vec[9]  = vr(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5),  1, 1, 0, 7, 5, 5, 0, 0, 0);
    vec[10] = vr(vin(0, 0, 1, 8, 2, 0, 1, 0, 1, 1, 0, 0),  1, 0, 0, 0, 0, 0, 0, 0, 0);
    vec[11] = vr(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6),  1, 0, 1, 8, 6, 6, 0, 0, 0);
    vec[12] = vr(vin(0, 0, 1, 9, 1, 1, 1, 1, 0, 1, 0, 0),  1, 0, 0, 0, 0, 0, 0, 0, 0);
    vec[13] = vr(vin(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),  0, 0, 0, 0, 0, 0, 0, 0, 0);
    vec[14] = vr(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),  1, 0, 0, 0, 0, 0, 0, 0, 0);
    vec[15] = vr(vin(0, 0, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0),  1, 0, 0, 0, 0, 0, 0, 0, 0);
    vec[16] = vr(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7),  1, 1, 0, 0, 7, 7, 1, 0, 0);
    vec[17] = vr(vin(0, 0, 1, 10, 1, 2, 1, 1, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vec[18] = vr(vin(1, 0, 1, 11, 1, 2, 1, 1, 0, 0, 0, 2), 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vec[19] = vr(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),  1, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 20; k++) begin
`ifdef ISSUE_STAT_EN
      if (k == 5) st0 = stat_stall;
`endif
      step(vec[k].i, rs);
      chk("tbl_ready", {127'd0, rs}, {127'd0, vec[k].ready});
      chk("tbl_valid", {126'd0, iss_rs_valid, iss_lsb_valid}, {126'd0, vec[k].rs_v, vec[k].lsb_v});
      chk("tbl_rename", {119'd0, new_reg_id, new_ROB_id}, {119'd0, vec[k].new_reg, vec[k].new_rob});
      if (vec[k].rs_v || vec[k].lsb_v)
        chk("tbl_rob_id", {124'd0, iss_rob_id}, {124'd0, vec[k].rob_id});
      if (vec[k].chk_dep)
        chk("tbl_dep1", {123'd0, iss_dep1, iss_q1}, {123'd0, vec[k].dep1, vec[k].q1});
`ifdef ISSUE_STAT_EN
      if (k == 8) chk("tbl_stall4", {96'd0, stat_stall - st0}, 128'd4);
`endif
    end

    for (int n = 0; n < 800; n++) begin
      t.rst = ($urandom_range(49) == 0);
      t.rdy = ($urandom_range(9) != 0);
      t.clear = ($urandom_range(19) == 0);
      t.dv = ($urandom_range(9) < 6);
      t.rd = 5'($urandom);
      t.rs1 = 5'($urandom_range(3) == 0 ? 0 : $urandom);
      t.rs2 = 5'($urandom);
      t.u1 = ($urandom_range(3) != 0);
      t.u2 = ($urandom_range(1) != 0);
      t.mem = ($urandom_range(2) == 0);
      t.info = $urandom;
      t.rob_full = ($urandom_range(6) == 0);
      t.tail = RW'($urandom);
      t.rs_full = ($urandom_range(3) == 0);
      t.lsb_full = ($urandom_range(3) == 0);
      step(t, rs);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_issue_ctrl.md
REG_ISSUE_CTRL -- requirements
Module: reg_issue_ctrl

Interface
REQ-001 SHALL have ports: clk_in  in  1  system clock; single clock domain.
REQ-002 SHALL have ports: rst_in  in  1  reset; synchronous, active-high.
REQ-003 SHALL have ports: rdy_in  in  1  pause; all state holds when low.
REQ-004 SHALL have ports: clear_flag  in  1  misprediction flush.
REQ-005 SHALL have ports: dec_valid in 1, dec_ready out 1, dec_rd/dec_rs1/dec_rs2 in 5, dec_use_rs1/dec_use_rs2 in 1, dec_is_mem in 1, dec_info in 32; decoded-instruction handshake.
REQ-006 SHALL have ports: rob_full in 1, rob_tail in `ROB_WIDTH_BIT, rs_full in 1, lsb_full in 1; resource status.
REQ-007 SHALL have ports: ask_reg_id1/ask_reg_id2 out 5, new_reg_id out 5, new_ROB_id out `ROB_WIDTH_BIT; register-file query and rename.
REQ-008 SHALL have ports: rf_val1/rf_val2 in 32, rf_dep1/rf_dep2 in 1, rf_rob1/rf_rob2 in `ROB_WIDTH_BIT; register-file answers.
REQ-009 SHALL have ports: iss_rs_valid out 1, iss_lsb_valid out 1, iss_info out 32, iss_v1/iss_v2 out 32, iss_q1/iss_q2 out `ROB_WIDTH_BIT, iss_dep1/iss_dep2 out 1, iss_rob_id out `ROB_WIDTH_BIT, rob_alloc out 1; issue outputs.

Function
REQ-010 SHALL hold one decoded instruction in a single-entry buffer; states EMPTY and FULL.
REQ-011 SHALL drive dec_ready = 1 when EMPTY, or when FULL and the buffered instruction issues this cycle; dec_valid&&dec_ready loads the buffer at the clock edge.
REQ-012 SHALL issue a buffered instruction when !rob_full and target not full (lsb_full if dec_is_mem, else rs_full); otherwise stay FULL, outputs unchanged.
REQ-013 SHALL drive ask_reg_id1/2 combinationally from buffered rs1/rs2, forced to 0 when the source is unused or the buffer is EMPTY.
REQ-014 SHALL register issue outputs: one cycle after the issue decision, pulse iss_rs_valid or iss_lsb_valid and rob_alloc for one cycle, with iss_rob_id = rob_tail sampled at issue.
REQ-015 SHALL register iss_dep1/iss_v1/iss_q1 from rf_dep1/rf_val1/rf_rob1 at issue; for x0 or an unused source, dep = 0 and v = 0. Source 2 follows the same rule.
REQ-016 SHALL drive new_reg_id/new_ROB_id as registers for exactly the cycle after issue: new_reg_id = rd, or 0 when rd = 0; new_reg_id = 0 in all other cycles.
REQ-017 SHALL issue back-to-back, one instruction per cycle. A consumer whose source matches the previous instruction's rd gets its dependency through the register file's same-cycle new_reg_id forwarding.
REQ-018 SHALL treat clear_flag as dominant: buffer to EMPTY; no issue that cycle; outputs of the next cycle zero (valid, rob_alloc, new_reg_id); dec_ready = 0 during the clear cycle.
REQ-019 SHALL, when rdy_in = 0, hold all registers; dec_ready and ask ids still follow the held state.

Reset
REQ-020 SHALL, on rst_in, synchronously set state EMPTY and drive every registered output to 0 (valids, rob_alloc, new_reg_id, new_ROB_id, iss_* data).
REQ-021 SHALL give rst_in priority over clear_flag and rdy_in; reset mid-issue discards the in-flight instruction.

Configuration
REQ-022 SHALL compile in, with ISSUE_STAT_EN defined, 32-bit outputs stat_issued (count of issues) and stat_stall (count of cycles FULL without issue). Both reset to 0, wrap modulo 2^32, and are not affected by clear_flag.
REQ-023 SHALL omit these ports and counters without ISSUE_STAT_EN; function otherwise identical.

Structure
REQ-024 SHALL take ROB_WIDTH_BIT and state encodings (ST_EMPTY, ST_FULL) from shared const.v.
REQ-025 SHALL implement the buffer as sub-module issue_buf (one-entry valid/ready holding register); the rest stays in reg_issue_ctrl.

Verification
REQ-026 Bench case: ADD rd=5 issued, rob_tail=3 -> next cycle iss_rs_valid=1, iss_rob_id=3, new_reg_id=5, new_ROB_id=3; cycle after, new_reg_id=0.
REQ-027 Bench case: back-to-back ADD rd=5 then SUB rs1=5 -> SUB issues the next cycle with iss_dep1=1 and iss_q1 equal to the first ROB id.
REQ-028 Bench case: rs_full=1 for 4 cycles with a buffered ALU op -> no valid, dec_ready=0, stat_stall+=4 (ISSUE_STAT_EN); issues the cycle rs_full falls.
REQ-029 Bench case: LW with lsb_full=0, rs_full=1 -> iss_lsb_valid=1, iss_rs_valid=0.
REQ-030 Bench case: clear_flag while FULL -> next cycle all valids 0, new_reg_id=0, state EMPTY, dec_ready=1.
REQ-031 Bench case: rs1=x0, rd=0 -> iss_dep1=0, iss_v1=0, new_reg_id stays 0; rst_in mid-issue -> all outputs 0 next cycle.
